instr_mem_loadable: RTL and testbench
=====================================

// Module: instr_mem_loadable
// PURPOSE
//  Parametrised, clocked instruction memory for the processor datapath, successor to the fixed 32x32 ROM.
//  Program is streamed in through a load port, so no program is hard-coded.
//  Instructions are then fetched by PC with a registered one-cycle read.
//  Unprogrammed, out-of-range and misaligned fetches return a HALT word and raise a fault flag.
// PARAMETERS
//  DATA_W     32            instruction width
//  PC_W       32            width of incoming PC
//  DEPTH      64            number of instruction words (power of two not required)
//  BYTE_ADDR  0             0: PC is a word index; 1: PC is a byte address, word index = PC>>2
//  NOP_WORD   32'h00000000  value of instr_out after reset
//  HALT_WORD  32'hFC000000  opcode 111111 (halt), returned on any fetch fault
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  load_start     in   1       begin new program load (pulse)
//  load_valid     in   1       load_data valid this cycle
//  load_data      in   DATA_W  next instruction word, written sequentially from word 0
//  load_last      in   1       qualifies load_valid: final word of program
//  load_busy      out  1       1 while in LOADING
//  load_done      out  1       one-cycle pulse when a load completes
//  load_overflow  out  1       sticky: words offered beyond DEPTH were dropped
//  prog_len       out  clog2(DEPTH+1)  number of valid programmed words
//  fetch_req      in   1       fetch instruction at pc
//  pc             in   PC_W    program counter
//  instr_valid    out  1       instr_out/fetch_fault valid this cycle
//  instr_out      out  DATA_W  fetched instruction
//  fetch_fault    out  1       fetch was out of range / unprogrammed / misaligned
// BEHAVIOUR
//  Reset (async): state=EMPTY, wr_ptr=0, prog_len=0, load_busy=0, load_done=0, load_overflow=0,
//   instr_valid=0, instr_out=NOP_WORD, fetch_fault=0. Memory array is NOT cleared; prog_len=0 masks it.
//  FSM states EMPTY, LOADING, READY:
//   load_start in any state -> LOADING next edge; wr_ptr=0, prog_len=0, load_overflow=0.
//   load_start during LOADING restarts the load; words written so far are discarded.
//   LOADING, load_valid=1: if wr_ptr<DEPTH write mem[wr_ptr], wr_ptr++; else drop word, set load_overflow.
//   LOADING, load_valid & load_last -> READY; prog_len = min(words accepted incl. this one, DEPTH);
//    load_done=1 for exactly the following cycle.
//   load_last without load_valid is ignored. load_valid outside LOADING is ignored (no write).
//   load_start and load_valid in the same cycle: load_start wins, data is ignored.
//  Fetch, 1-cycle latency: fetch_req sampled at edge N -> instr_valid=1 during cycle N+1 with result.
//   idx = BYTE_ADDR ? pc>>2 : pc. Fault if idx>=prog_len, or BYTE_ADDR=1 and pc[1:0]!=0.
//   Fault: instr_out=HALT_WORD, fetch_fault=1. Else instr_out=mem[idx], fetch_fault=0.
//   Comparison uses the full PC_W value: upper PC bits are never truncated and wrapped into range.
//   fetch_req=0 or state LOADING: instr_valid=0 next cycle; instr_out and fetch_fault hold their values.
//   EMPTY: every fetch faults (prog_len=0).
//   Back-to-back fetches every cycle are supported; throughput is one per cycle.
//   A load_start in the same cycle as fetch_req: the fetch is ignored.
//  Reset mid-load: prog_len returns to 0; the partial program is unusable until a fresh load completes.
// TESTING
//  1. Reset then fetch pc=0 -> next cycle instr_valid=1, instr_out=32'hFC000000, fetch_fault=1.
//  2. Load 3 words {18000001,18200003,00000000} with last on word 3 -> load_done pulse, prog_len=3;
//     fetch pc=1 -> 32'h18200003, no fault; pc=3 -> HALT word, fault=1.
//  3. DEPTH=4: stream 6 words, last on 6th -> load_overflow=1, prog_len=4;
//     pc=3 returns word 4; pc=4 faults.
//  4. Restart: mid-load, assert load_start -> reload 2 words -> prog_len=2; first load data is not visible.
//  5. BYTE_ADDR=1, program loaded: pc=8 -> word 2; pc=9 -> HALT word, fault=1;
//     pc=32'h80000000 -> fault, no wrap.
//  6. Fetch every cycle during LOADING -> instr_valid stays 0;
//     async rst mid-load -> all outputs at reset values immediately.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: a program is streamed in through the load port,
// then fetched by PC with a registered one-cycle read and fault reporting.
module instr_mem_loadable #(
    parameter int                 DATA_W    = 32,
    parameter int                 PC_W      = 32,
    parameter int                 DEPTH     = 64,
    parameter int                 BYTE_ADDR = 0,
    parameter logic [DATA_W-1:0]  NOP_WORD  = '0,
    parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(32'hFC000000),
    localparam int                LW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_overflow,
    output logic [LW-1:0]     prog_len,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic              fetch_fault
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (PC_W > LW) ? PC_W : LW;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [LW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]       prog_len_q, prog_len_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                fault_q, fault_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                word_in_s;
    logic                room_s;
    logic                wr_en_s;
    logic                fetch_s;
    logic                misalign_s;
    logic                fault_s;
    logic [PC_W-1:0]     idx_s;
    logic [CW-1:0]       idx_ext_s;
    logic [CW-1:0]       len_ext_s;

    // Load FSM: a load_start always wins and restarts from word 0.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        wr_en_s    = 1'b0;
        word_in_s  = (state_q == ST_LOADING) && load_valid && !load_start;
        room_s     = (wr_ptr_q < LW'(DEPTH));
        if (load_start) begin
            state_d    = ST_LOADING;
            wr_ptr_d   = '0;
            prog_len_d = '0;
            ovf_d      = 1'b0;
        end else if (word_in_s) begin
            if (room_s) begin
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + LW'(1);
            end else begin
                ovf_d = 1'b1;
            end
            if (load_last) begin
                state_d    = ST_READY;
                prog_len_d = room_s ? (wr_ptr_q + LW'(1)) : LW'(DEPTH);
                done_d     = 1'b1;
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Fetch path: range check on the full-width index so high PC bits never alias.
    always_comb begin
        idx_s      = (BYTE_ADDR != 0) ? (pc >> 2) : pc;
        misalign_s = (BYTE_ADDR != 0) && (pc[1:0] != 2'b00);
        idx_ext_s  = CW'(idx_s);
        len_ext_s  = CW'(prog_len_q);
        fault_s    = misalign_s || (idx_ext_s >= len_ext_s);
        fetch_s    = fetch_req && !load_start && (state_q != ST_LOADING);
        valid_d    = fetch_s;
        instr_d    = instr_q;
        fault_d    = fault_q;
        if (fetch_s) begin
            if (fault_s) begin
                instr_d = HALT_WORD;
                fault_d = 1'b1;
            end else begin
                instr_d = mem_q[idx_s[IW-1:0]];
                fault_d = 1'b0;
            end
        end else begin
            instr_d = instr_q;
            fault_d = fault_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= NOP_WORD;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
        end
    end

    // Storage array; left uncleared by reset since prog_len masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[IW-1:0]] <= load_data;
        end
    end

    assign load_busy     = (state_q == ST_LOADING);
    assign load_done     = done_q;
    assign load_overflow = ovf_q;
    assign prog_len      = prog_len_q;
    assign instr_valid   = valid_q;
    assign instr_out     = instr_q;
    assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench: three instances (word-indexed, DEPTH=4, byte-addressed) share
// one stimulus stream and are checked against hand-computed values.
module tb_instr_mem_loadable;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data  = 32'h0;
    logic        load_last  = 1'b0;
    logic        fetch_req  = 1'b0;
    logic [31:0] pc         = 32'h0;

    logic        m_busy, m_done, m_ovf, m_valid, m_fault;
    logic [6:0]  m_len;
    logic [31:0] m_instr;
    logic        d_busy, d_done, d_ovf, d_valid, d_fault;
    logic [2:0]  d_len;
    logic [31:0] d_instr;
    logic        b_busy, b_done, b_ovf, b_valid, b_fault;
    logic [6:0]  b_len;
    logic [31:0] b_instr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_mem_loadable u_main (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_busy(m_busy),
        .load_done(m_done), .load_overflow(m_ovf), .prog_len(m_len),
        .fetch_req(fetch_req), .pc(pc), .instr_valid(m_valid),
        .instr_out(m_instr), .fetch_fault(m_fault)
    );

    instr_mem_loadable #(.DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_busy(d_busy),
        .load_done(d_done), .load_overflow(d_ovf), .prog_len(d_len),
        .fetch_req(fetch_req), .pc(pc), .instr_valid(d_valid),
        .instr_out(d_instr), .fetch_fault(d_fault)
    );

    instr_mem_loadable #(.BYTE_ADDR(1)) u_ba (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_busy(b_busy),
        .load_done(b_done), .load_overflow(b_ovf), .prog_len(b_len),
        .fetch_req(fetch_req), .pc(pc), .instr_valid(b_valid),
        .instr_out(b_instr), .fetch_fault(b_fault)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        fetch_req = 1'b1;
        pc        = addr;
        step();
        fetch_req = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check_eq("rst_valid", m_valid, 0);
        check_eq("rst_instr", m_instr, 32'h00000000);
        check_eq("rst_fault", m_fault, 0);
        check_eq("rst_len",   m_len, 0);
        check_eq("rst_busy",  m_busy, 0);
        check_eq("rst_done",  m_done, 0);
        check_eq("rst_ovf",   m_ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch from an empty memory
        fetch(32'd0);
        check_eq("empty_valid", m_valid, 1);
        check_eq("empty_instr", m_instr, 32'hFC000000);
        check_eq("empty_fault", m_fault, 1);

        // Three-word program
        start_load();
        check_eq("ld1_busy", m_busy, 1);
        load_word(32'h18000001, 1'b0);
        load_word(32'h18200003, 1'b0);
        load_word(32'h00000000, 1'b1);
        check_eq("ld1_done", m_done, 1);
        check_eq("ld1_len",  m_len, 3);
        check_eq("ld1_busy_off", m_busy, 0);
        step();
        check_eq("ld1_done_pulse", m_done, 0);

        fetch_req = 1'b1;
        pc = 32'd1;
        step();
        check_eq("p1_valid", m_valid, 1);
        check_eq("p1_instr", m_instr, 32'h18200003);
        check_eq("p1_fault", m_fault, 0);
        check_eq("b_p1_misalign", b_fault, 1);
        pc = 32'd3;
        step();
        check_eq("p3_valid", m_valid, 1);
        check_eq("p3_instr", m_instr, 32'hFC000000);
        check_eq("p3_fault", m_fault, 1);
        fetch_req = 1'b0;
        step();
        check_eq("idle_valid", m_valid, 0);
        check_eq("idle_hold_instr", m_instr, 32'hFC000000);
        check_eq("idle_hold_fault", m_fault, 1);

        // Six words: DEPTH=4 instance overflows
        start_load();
        for (int i = 0; i < 6; i++) begin
            load_word(32'hA0000000 + 32'(i), (i == 5) ? 1'b1 : 1'b0);
        end
        check_eq("d4_ovf", d_ovf, 1);
        check_eq("d4_len", d_len, 4);
        check_eq("d4_done", d_done, 1);
        check_eq("m_len6", m_len, 6);
        check_eq("m_ovf0", m_ovf, 0);
        fetch(32'd3);
        check_eq("d4_p3_instr", d_instr, 32'hA0000003);
        check_eq("d4_p3_fault", d_fault, 0);
        fetch(32'd4);
        check_eq("d4_p4_instr", d_instr, 32'hFC000000);
        check_eq("d4_p4_fault", d_fault, 1);
        check_eq("m_p4_instr", m_instr, 32'hA0000004);
        fetch(32'h80000001);
        check_eq("m_hipc_fault", m_fault, 1);
        check_eq("m_hipc_instr", m_instr, 32'hFC000000);
        fetch(32'd8);
        check_eq("b_p8_instr", b_instr, 32'hA0000002);
        check_eq("b_p8_fault", b_fault, 0);
        fetch(32'd9);
        check_eq("b_p9_instr", b_instr, 32'hFC000000);
        check_eq("b_p9_fault", b_fault, 1);
        fetch(32'd20);
        check_eq("b_p20_instr", b_instr, 32'hA0000005);
        fetch(32'd24);
        check_eq("b_p24_fault", b_fault, 1);
        fetch(32'h80000000);
        check_eq("b_hipc_fault", b_fault, 1);
        check_eq("b_hipc_instr", b_instr, 32'hFC000000);

        // Restart mid-load; start beats a simultaneous valid+last
        start_load();
        load_word(32'hB0000000, 1'b0);
        load_word(32'hB0000001, 1'b0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
        load_last  = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        check_eq("rs_busy", m_busy, 1);
        check_eq("rs_done", m_done, 0);
        check_eq("rs_len0", m_len, 0);
        load_word(32'hC0000000, 1'b0);
        load_word(32'hC0000001, 1'b1);
        check_eq("rs_len2", m_len, 2);
        check_eq("rs_d4_ovf_clr", d_ovf, 0);
        step();
        load_valid = 1'b1;
        load_data  = 32'h11111111;
        load_last  = 1'b1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        check_eq("ign_len", m_len, 2);
        check_eq("ign_done", m_done, 0);
        check_eq("ign_busy", m_busy, 0);
        fetch(32'd0);
        check_eq("rs_p0", m_instr, 32'hC0000000);
        fetch(32'd1);
        check_eq("rs_p1", m_instr, 32'hC0000001);
        fetch(32'd2);
        check_eq("rs_p2_fault", m_fault, 1);
        check_eq("rs_p2_instr", m_instr, 32'hFC000000);

        // Fetches during a load are dropped; async reset mid-load
        fetch_req  = 1'b1;
        pc         = 32'd0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check_eq("ls_fetch_valid", m_valid, 0);
        check_eq("ls_fetch_hold", m_instr, 32'hFC000000);
        load_last = 1'b1;
        step();
        load_last = 1'b0;
        check_eq("last_novalid_busy", m_busy, 1);
        check_eq("ld_fetch_valid", m_valid, 0);
        load_word(32'hD0000000, 1'b0);
        check_eq("ld_fetch_valid2", m_valid, 0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy",  m_busy, 0);
        check_eq("arst_len",   m_len, 0);
        check_eq("arst_valid", m_valid, 0);
        check_eq("arst_instr", m_instr, 32'h00000000);
        check_eq("arst_fault", m_fault, 0);
        check_eq("arst_done",  m_done, 0);
        @(negedge clk);
        rst = 1'b0;
        fetch_req = 1'b0;
        fetch(32'd0);
        check_eq("post_rst_fault", m_fault, 1);
        check_eq("post_rst_instr", m_instr, 32'hFC000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
